// File: rtl/register_file_pkg.sv
// rtl/register_file_pkg.sv - shared sizing constants and index type for the integer register file
package register_file_pkg;

  localparam int XLEN      = 32;
  localparam int NREGS     = 32;
  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - pending-load scoreboard with decode-stage stall compare
module regfile_scoreboard
  import register_file_pkg::*;
#(
  parameter int NREGS = register_file_pkg::NREGS
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     set_en,
  input  reg_idx_t set_idx,
  input  logic     clr_en,
  input  reg_idx_t clr_idx,
  input  reg_idx_t rs1_idx,
  input  reg_idx_t rs2_idx,
  input  logic     rs1_bypass,
  input  logic     rs2_bypass,
  output logic     busy_stall
);

  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_d;

  always_comb begin
    pending_d = pending_q;
    if (clr_en) begin
      pending_d[clr_idx] = 1'b0;
    end
    // Set is applied after clear so a younger load marking the same index wins.
    if (set_en) begin
      pending_d[set_idx] = 1'b1;
    end
    pending_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  always_comb begin
    busy_stall = rst && ((pending_q[rs1_idx] && !rs1_bypass) ||
                         (pending_q[rs2_idx] && !rs2_bypass));
  end

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - RV32I integer register file with writeback bypass and load scoreboard
module register_file #(
  parameter int NREGS = register_file_pkg::NREGS,
  parameter int XLEN  = register_file_pkg::XLEN
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        RegWriteW,
  input  register_file_pkg::reg_idx_t RdW,
  input  logic [XLEN-1:0]             ResultW,
  input  register_file_pkg::reg_idx_t Rs1D,
  input  register_file_pkg::reg_idx_t Rs2D,
  output logic [XLEN-1:0]             RD1D,
  output logic [XLEN-1:0]             RD2D,
  input  logic                        LoadMarkE,
  input  register_file_pkg::reg_idx_t RdE,
  output logic                        BusyStallD
);
  import register_file_pkg::*;

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  logic wr_en;
  logic mark_en;
  logic rs1_bypass;
  logic rs2_bypass;

  always_comb begin
    wr_en      = RegWriteW && (RdW != ZERO_REG);
    mark_en    = LoadMarkE && (RdE != ZERO_REG);
    rs1_bypass = wr_en && (RdW == Rs1D);
    rs2_bypass = wr_en && (RdW == Rs2D);
  end

  // x0 is never written, so regs_q[0] stays at its reset value of zero.
  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[RdW] = ResultW;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Outputs are forced to zero while reset is held so the bypass cannot leak ResultW.
  always_comb begin
    RD1D = '0;
    RD2D = '0;
    if (rst) begin
      RD1D = rs1_bypass ? ResultW : regs_q[Rs1D];
      RD2D = rs2_bypass ? ResultW : regs_q[Rs2D];
    end
  end

  regfile_scoreboard #(
    .NREGS(NREGS)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_en    (mark_en),
    .set_idx   (RdE),
    .clr_en    (wr_en),
    .clr_idx   (RdW),
    .rs1_idx   (Rs1D),
    .rs2_idx   (Rs2D),
    .rs1_bypass(rs1_bypass),
    .rs2_bypass(rs2_bypass),
    .busy_stall(BusyStallD)
  );

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter: NREGS, default 32, number of architectural integer registers (fixed 32 for RV32I).
REQ-002 Parameter: XLEN, default 32, register data width.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-low.
REQ-005 Port: RegWriteW  input  1  writeback-stage write enable.
REQ-006 Port: RdW  input  5  writeback destination register index.
REQ-007 Port: ResultW  input  XLEN  writeback result data.
REQ-008 Port: Rs1D, Rs2D  input  5 each  decode-stage source register indices.
REQ-009 Port: RD1D, RD2D  output  XLEN each  decode-stage source operand data.
REQ-010 Port: LoadMarkE  input  1  execute stage holds a load; mark RdE pending.
REQ-011 Port: RdE  input  5  execute-stage destination index.
REQ-012 Port: BusyStallD  output  1  a decode source is pending on an in-flight load.

Function
REQ-013 Storage: NREGS x XLEN array; x0 reads 0 always; writes to x0 ignored.
REQ-014 Write: on rising clk with RegWriteW=1 and RdW!=0, reg[RdW] <= ResultW; 1-cycle write latency.
REQ-015 Read: RD1D/RD2D combinational from array, 0-cycle latency.
REQ-016 Bypass: RegWriteW=1, RdW!=0, RdW==Rs1D -> RD1D=ResultW same cycle; likewise Rs2D/RD2D; both ports bypass independently when Rs1D==Rs2D==RdW.
REQ-017 Scoreboard: NREGS-bit pending vector; bit 0 never set.
REQ-018 Set: rising clk with LoadMarkE=1 and RdE!=0 -> pending[RdE] <= 1.
REQ-019 Clear: rising clk with RegWriteW=1 and RdW!=0 -> pending[RdW] <= 0.
REQ-020 Simultaneous set and clear of same index in one cycle -> set wins (younger load).
REQ-021 BusyStallD = (pending[Rs1D] | pending[Rs2D]) and not bypassed: a source matching REQ-016 bypass does not stall.
REQ-022 Stall output combinational; no added cycle latency.
REQ-023 Indices are 5-bit; no out-of-range handling needed for NREGS=32.

Reset
REQ-024 rst=0 asynchronously clears all registers to 0 and all pending bits to 0.
REQ-025 During reset: RD1D=RD2D=0, BusyStallD=0; writes and marks ignored.
REQ-026 Reset deassertion mid-operation: first rising clk after rst=1 performs normal writes/marks.

Structure
REQ-027 Shared package: XLEN, NREGS, register-index width 5, constant ZERO_REG=0.
REQ-028 One natural sub-module: regfile_scoreboard (pending vector, set/clear, stall compare); array and bypass in top.
REQ-029 No memory macros; flops only; no combinational loop between ResultW and outputs other than the bypass path.

Verification
REQ-030 Reset: rst=0 with RegWriteW=1, RdW=5, ResultW=0xDEADBEEF -> after rst=1, Rs1D=5 gives RD1D=0.
REQ-031 Write/read: write x7=0x12345678, next cycle Rs1D=7,Rs2D=7 -> RD1D=RD2D=0x12345678.
REQ-032 x0: RegWriteW=1, RdW=0, ResultW=0xFFFFFFFF; Rs1D=0 same and next cycle -> RD1D=0, no bypass.
REQ-033 Bypass: x3 holds 0x1; cycle with RegWriteW=1,RdW=3,ResultW=0xAA and Rs2D=3 -> RD2D=0xAA same cycle.
REQ-034 Scoreboard: LoadMarkE=1,RdE=9; next cycle Rs1D=9 -> BusyStallD=1; later RegWriteW=1,RdW=9,ResultW=0x55 -> BusyStallD=0, RD1D=0x55 that cycle; pending clear after edge.
REQ-035 Collision: same edge LoadMarkE=1,RdE=4 and RegWriteW=1,RdW=4 -> reg[4] updated, pending[4]=1 afterward, BusyStallD=1 for Rs1D=4.
